// File: rtl/screen_arbiter_if.sv
// Bus bundle between the character-RAM arbiter, its three users and the RAM.
// The arbiter side uses the slave modport; users, the RAM and benches use master.
interface screen_arbiter_if;
  // display fetch path
  logic       vid_req;
  logic [4:0] vid_row;
  logic [6:0] vid_col;
  logic [7:0] vid_char;
  logic       vid_valid;
  // terminal writer
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_row;
  logic [6:0] wr_col;
  logic [7:0] wr_char;
  // clear-screen control
  logic       clr_start;
  logic [7:0] clr_char;
  logic       busy;
  logic       done;
  // single-port character RAM
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  modport slave (
    input  vid_req, vid_row, vid_col,
    output vid_char, vid_valid,
    input  wr_valid, wr_row, wr_col, wr_char,
    output wr_ready,
    input  clr_start, clr_char,
    output busy, done,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output vid_req, vid_row, vid_col,
    input  vid_char, vid_valid,
    output wr_valid, wr_row, wr_col, wr_char,
    input  wr_ready,
    output clr_start, clr_char,
    input  busy, done,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/screen_arbiter.sv
// Character-RAM arbiter: display fetch (absolute priority, 1-cycle latency),
// clear-screen sequencer and terminal writer share one single-port RAM.
module screen_arbiter #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 24,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          reset_n,
  screen_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_clr_row, w_clr_row_nxt;
  logic [6:0]  r_clr_col, w_clr_col_nxt;
  logic [7:0]  r_clr_fill, w_clr_fill_nxt;
  logic        r_done, w_done_nxt;
  logic        r_vid_valid, r_vid_oor;
  logic [7:0]  r_vid_hold;
  logic [7:0]  w_vid_char;
  logic        w_vid_oor, w_wr_in_range, w_clr_last;

  assign w_vid_oor     = ({1'b0, bus.vid_row} >= 6'(ROWS)) || ({1'b0, bus.vid_col} >= 8'(COLS));
  assign w_wr_in_range = ({1'b0, bus.wr_row}  <  6'(ROWS)) && ({1'b0, bus.wr_col}  <  8'(COLS));
  assign w_clr_last    = (r_clr_row == LAST_ROW) && (r_clr_col == LAST_COL);

  // Character lands together with vid_valid, then holds until the next fetch.
  assign w_vid_char    = r_vid_oor ? BLANK : bus.ram_rdata;
  assign bus.vid_char  = r_vid_valid ? w_vid_char : r_vid_hold;
  assign bus.vid_valid = r_vid_valid;
  assign bus.busy      = (r_state == S_CLEAR);
  assign bus.done      = r_done;
  // Reset is folded in so the writer never sees ready while the block is held.
  assign bus.wr_ready  = (r_state == S_IDLE) && !bus.vid_req && reset_n;

  // FSM state and clear counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_clr_row  <= '0;
      r_clr_col  <= '0;
      r_clr_fill <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_row  <= w_clr_row_nxt;
      r_clr_col  <= w_clr_col_nxt;
      r_clr_fill <= w_clr_fill_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next state: clear only advances in cycles where video leaves the port free
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_row_nxt  = r_clr_row;
    w_clr_col_nxt  = r_clr_col;
    w_clr_fill_nxt = r_clr_fill;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_start) begin
          w_state_nxt    = S_CLEAR;
          w_clr_fill_nxt = bus.clr_char;
          w_clr_row_nxt  = '0;
          w_clr_col_nxt  = '0;
        end
      end
      S_CLEAR: begin
        if (!bus.vid_req) begin
          if (w_clr_last) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_clr_col == LAST_COL) begin
            w_clr_col_nxt = '0;
            w_clr_row_nxt = r_clr_row + 5'd1;
          end else begin
            w_clr_col_nxt = r_clr_col + 7'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RAM port owner: video, then clear sequencer, then writer (in-range only)
  always_comb begin
    bus.ram_addr  = {bus.wr_row, bus.wr_col};
    bus.ram_we    = 1'b0;
    bus.ram_wdata = bus.wr_char;
    if (bus.vid_req) begin
      bus.ram_addr = {bus.vid_row, bus.vid_col};
    end else if (r_state == S_CLEAR) begin
      bus.ram_addr  = {r_clr_row, r_clr_col};
      bus.ram_we    = 1'b1;
      bus.ram_wdata = r_clr_fill;
    end else if (bus.wr_valid && reset_n) begin
      bus.ram_we = w_wr_in_range;
    end
  end

  // Display fetch pipeline: valid, range flag and held character
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vid_valid <= 1'b0;
      r_vid_oor   <= 1'b0;
      r_vid_hold  <= BLANK;
    end else begin
      r_vid_valid <= bus.vid_req;
      if (bus.vid_req) r_vid_oor <= w_vid_oor;
      if (r_vid_valid) r_vid_hold <= w_vid_char;
    end
  end

endmodule

// File: tb/tb_screen_arbiter.sv
// Directed bench for screen_arbiter with a behavioural single-port RAM.
module tb_screen_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic mem_fill;
  logic [7:0] mem [0:4095];
  int n_checks = 0;
  int n_fail   = 0;

  screen_arbiter_if bus();

  screen_arbiter #(.COLS(80), .ROWS(24), .BLANK(8'h20)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM model: registered read, write on ram_we
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'hA5;
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vreq; logic [4:0] vrow; logic [6:0] vcol;
    logic       wv;   logic [4:0] wrow; logic [6:0] wcol; logic [7:0] wch;
    logic       e_rdy; logic e_we; logic [11:0] e_addr; logic e_vv; logic [7:0] e_vc;
  } vec_t;

  vec_t tv [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nwrites, bad_seq, bad_rdy, done_in, er, ec, bad, nw;
    logic finished;

    tv[0]  = '{0, 0, 0,   1, 3, 5, 8'h41,  1, 1, 12'h185, 0, 8'h20};
    tv[1]  = '{1, 3, 5,   0, 0, 0, 8'h00,  0, 0, 12'h185, 0, 8'h20};
    tv[2]  = '{0, 0, 0,   0, 0, 0, 8'h00,  1, 0, 12'h000, 1, 8'h41};
    tv[3]  = '{1, 3, 5,   1, 1, 2, 8'h55,  0, 0, 12'h185, 0, 8'h41};
    tv[4]  = '{1, 3, 5,   1, 1, 2, 8'h55,  0, 0, 12'h185, 1, 8'h41};
    tv[5]  = '{1, 3, 5,   1, 1, 2, 8'h55,  0, 0, 12'h185, 1, 8'h41};
    tv[6]  = '{1, 3, 5,   1, 1, 2, 8'h55,  0, 0, 12'h185, 1, 8'h41};
    tv[7]  = '{0, 0, 0,   1, 1, 2, 8'h55,  1, 1, 12'h082, 1, 8'h41};
    tv[8]  = '{0, 0, 0,   1, 24, 0, 8'h99, 1, 0, 12'hC00, 0, 8'h41};
    tv[9]  = '{0, 0, 0,   1, 0, 80, 8'h99, 1, 0, 12'h050, 0, 8'h41};
    tv[10] = '{1, 0, 100, 0, 0, 0, 8'h00,  0, 0, 12'h064, 0, 8'h41};
    tv[11] = '{0, 0, 0,   0, 0, 0, 8'h00,  1, 0, 12'h000, 1, 8'h20};
    tv[12] = '{1, 1, 2,   0, 0, 0, 8'h00,  0, 0, 12'h082, 0, 8'h20};
    tv[13] = '{0, 0, 0,   0, 0, 0, 8'h00,  1, 0, 12'h000, 1, 8'h55};
    tv[14] = '{1, 24, 0,  0, 0, 0, 8'h00,  0, 0, 12'hC00, 0, 8'h55};
    tv[15] = '{0, 0, 0,   0, 0, 0, 8'h00,  1, 0, 12'h000, 1, 8'h20};

    // Reset with writer and clear requests active
    reset_n = 1'b0; mem_fill = 1'b1;
    bus.vid_req = 0; bus.vid_row = 0; bus.vid_col = 0;
    bus.wr_valid = 1; bus.wr_row = 3; bus.wr_col = 5; bus.wr_char = 8'h41;
    bus.clr_start = 1; bus.clr_char = 8'h11; bus.ram_rdata = 8'h00;
    @(posedge clk); #1 mem_fill = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_vid_valid", bus.vid_valid, 0);
    check("rst_vid_char", bus.vid_char, 8'h20);
    @(negedge clk);
    reset_n = 1'b1; bus.wr_valid = 0; bus.clr_start = 0;
    #1;
    check("post_rst_wr_ready", bus.wr_ready, 1);
    check("post_rst_busy", bus.busy, 0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.vid_req = tv[i].vreq; bus.vid_row = tv[i].vrow; bus.vid_col = tv[i].vcol;
      bus.wr_valid = tv[i].wv; bus.wr_row = tv[i].wrow; bus.wr_col = tv[i].wcol;
      bus.wr_char = tv[i].wch;
      #1;
      check($sformatf("v%0d_wr_ready", i), bus.wr_ready, tv[i].e_rdy);
      check($sformatf("v%0d_ram_we", i), bus.ram_we, tv[i].e_we);
      if (tv[i].vreq || tv[i].wv)
        check($sformatf("v%0d_ram_addr", i), bus.ram_addr, tv[i].e_addr);
      if (tv[i].e_we)
        check($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, tv[i].wch);
      check($sformatf("v%0d_vid_valid", i), bus.vid_valid, tv[i].e_vv);
      check($sformatf("v%0d_vid_char", i), bus.vid_char, tv[i].e_vc);
    end

    // Full clear with periodic video, restart attempt and pending writer
    @(negedge clk);
    bus.vid_req = 0; bus.wr_valid = 0; bus.clr_start = 1; bus.clr_char = 8'h2E;
    #1 check("clr_start_busy", bus.busy, 0);
    cyc = 0; nwrites = 0; bad_seq = 0; bad_rdy = 0; done_in = 0; er = 0; ec = 0;
    finished = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      if (!bus.busy) begin
        finished = 1;
        break;
      end
      bus.vid_req = (cyc % 10 == 9); bus.vid_row = 0; bus.vid_col = 0;
      bus.clr_start = (cyc == 50); bus.clr_char = (cyc == 50) ? 8'hFF : 8'h2E;
      bus.wr_valid = 1; bus.wr_row = 2; bus.wr_col = 2; bus.wr_char = 8'h77;
      #1;
      if (bus.wr_ready) bad_rdy++;
      if (bus.done) done_in++;
      if (bus.vid_req) begin
        if (bus.ram_we) bad_seq++;
      end else begin
        if (!bus.ram_we || bus.ram_addr !== {5'(er), 7'(ec)} || bus.ram_wdata !== 8'h2E) bad_seq++;
        nwrites++; ec++;
        if (ec == 80) begin ec = 0; er++; end
      end
      cyc++;
    end
    check("clear_finished", finished, 1);
    check("clear_writes", nwrites, 1920);
    check("clear_sequence_errors", bad_seq, 0);
    check("ready_during_clear", bad_rdy, 0);
    check("done_while_busy", done_in, 0);
    bus.vid_req = 0; bus.clr_start = 0;
    #1;
    check("done_pulse", bus.done, 1);
    check("pending_wr_ready", bus.wr_ready, 1);
    check("pending_wr_we", bus.ram_we, 1);
    check("pending_wr_addr", bus.ram_addr, 12'h102);
    check("pending_wr_data", bus.ram_wdata, 8'h77);
    @(negedge clk);
    bus.wr_valid = 0;
    #1;
    check("done_one_cycle", bus.done, 0);
    check("no_restart", bus.busy, 0);
    bad = 0;
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 80; c++)
        if (mem[{5'(r), 7'(c)}] !== ((r == 2 && c == 2) ? 8'h77 : 8'h2E)) bad++;
    check("filled_cells", bad, 0);
    check("cell_0_80_untouched", mem[12'h050], 8'hA5);
    check("cell_24_0_untouched", mem[12'hC00], 8'hA5);
    @(negedge clk);
    bus.vid_req = 1; bus.vid_row = 10; bus.vid_col = 10;
    @(negedge clk);
    bus.vid_req = 0;
    #1;
    check("read_cleared_valid", bus.vid_valid, 1);
    check("read_cleared_char", bus.vid_char, 8'h2E);

    // Reset in the middle of a clear
    @(negedge clk);
    bus.clr_start = 1; bus.clr_char = 8'h3C;
    nw = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      bus.clr_start = 0;
      #1;
      if (bus.ram_we && bus.busy) nw++;
    end
    check("partial_writes", nw, 500);
    @(negedge clk);
    reset_n = 0;
    #1;
    check("midclr_rst_busy", bus.busy, 0);
    check("midclr_rst_done", bus.done, 0);
    check("midclr_rst_we", bus.ram_we, 0);
    check("midclr_rst_ready", bus.wr_ready, 0);
    @(negedge clk);
    reset_n = 1;
    #1;
    check("after_rst_done", bus.done, 0);
    check("after_rst_busy", bus.busy, 0);
    check("after_rst_ready", bus.wr_ready, 1);
    bad = 0;
    for (int i = 0; i < 1920; i++)
      if (mem[{5'(i / 80), 7'(i % 80)}] !== ((i < 500) ? 8'h3C : 8'h2E)) bad++;
    check("partial_clear_cells", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
